// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU step driver.
//   drv_state_e  : sequencing FSM states
//   alu_ctrl_t   : registered ALU control bundle (op select + add/sub enables)
//   decode_step  : step index -> ALU controls
package alu_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    WAIT,
    CAPTURE
  } drv_state_e;

  localparam int unsigned NUM_STEPS = 10;
  localparam int unsigned STEP_SUM  = 8;
  localparam int unsigned STEP_SUB  = 9;

  typedef struct packed {
    logic [2:0] op;
    logic       op_sum;
    logic       op_subt;
  } alu_ctrl_t;

  // Steps 0..7 walk the logic ops in descending op code; steps 8/9 park the
  // op select at 3'b111 and enable the adder / subtractor instead.
  function automatic alu_ctrl_t decode_step(input logic [3:0] step);
    alu_ctrl_t c;
    c.op      = 3'b111;
    c.op_sum  = 1'b0;
    c.op_subt = 1'b0;
    if (step == 4'(STEP_SUM)) begin
      c.op_sum = 1'b1;
    end else if (step == 4'(STEP_SUB)) begin
      c.op_subt = 1'b1;
    end else begin
      c.op = ~step[2:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_step_driver_if.sv
// Bus between the step driver and the 4-bit ALU.
//   master : driver side (drives operands/controls, reads result/carries)
//   slave  : ALU side
interface alu_step_driver_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_op;
  logic         alu_op_sum;
  logic         alu_op_subt;
  logic [N-1:0] alu_result;
  logic         alu_carry_sum;
  logic         alu_carry_sub;

  modport master (
    output alu_a, alu_b, alu_op, alu_op_sum, alu_op_subt,
    input  alu_result, alu_carry_sum, alu_carry_sub
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_op_sum, alu_op_subt,
    output alu_result, alu_carry_sum, alu_carry_sub
  );
endinterface

// File: rtl/alu_step_driver_debounce.sv
// Active-low push-button debouncer with press detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n      : raw button pin, low = pressed
//   press      : one-cycle pulse when a debounced press is accepted
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      press  <= 1'b0;
      if (sync_q[1] != level_q) begin
        // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample;
        // a press is an accepted 1->0 change, so the old level is the pulse.
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          press   <= level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_step_driver.sv
// Board-level sequential driver for the 4-bit ALU. Latches operands from the
// switches on a load press and steps through the ten ALU modes on next
// presses, capturing result and carry once the ALU has settled.
//   clk, rst_n       : clock, asynchronous active-low reset
//   sw_a, sw_b       : operand switches (sampled only in LOAD)
//   btn_load_n       : load button, low = pressed
//   btn_next_n       : step button, low = pressed
//   alu              : ALU bus (operands/controls out, result/carries in)
//   result_q, carry_q: captured result and carry/borrow
//   step_q           : current step 0..9
//   done             : one-cycle pulse in the capture cycle
module alu_step_driver
  import alu_drv_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              sw_a,
  input  logic [N-1:0]              sw_b,
  input  logic                      btn_load_n,
  input  logic                      btn_next_n,
  alu_step_driver_if.master         alu,
  output logic [N-1:0]              result_q,
  output logic                      carry_q,
  output logic [3:0]                step_q,
  output logic                      done
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam alu_ctrl_t CTRL_RST = '{op: 3'b111, op_sum: 1'b0, op_subt: 1'b0};

  logic load_press;
  logic next_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_load_n),
    .press (load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_next_n),
    .press (next_press)
  );

  drv_state_e    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  alu_ctrl_t     ctrl_q, ctrl_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [N-1:0]  result_d;
  logic          carry_d;
  logic [3:0]    step_d;
  logic          done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= CTRL_RST;
      settle_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      step_q   <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      settle_q <= settle_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      step_q   <= step_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    settle_d = settle_q;
    result_d = result_q;
    carry_d  = carry_q;
    step_d   = step_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Load has priority; a simultaneous next press is dropped.
        if (load_press) begin
          state_d = LOAD;
        end else if (next_press) begin
          step_d  = (step_q == 4'(NUM_STEPS - 1)) ? 4'd0 : step_q + 4'd1;
          state_d = APPLY;
        end
      end
      LOAD: begin
        a_d     = sw_a;
        b_d     = sw_b;
        step_d  = '0;
        state_d = APPLY;
      end
      APPLY: begin
        ctrl_d   = decode_step(step_q);
        settle_d = SW'(SETTLE_CYCLES - 1);
        state_d  = WAIT;
      end
      WAIT: begin
        // done is registered, so it is raised on the way into CAPTURE to
        // line up with the capture cycle itself.
        if (settle_q == '0) begin
          state_d = CAPTURE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      CAPTURE: begin
        result_d = alu.alu_result;
        if (step_q == 4'(STEP_SUM)) begin
          carry_d = alu.alu_carry_sum;
        end else if (step_q == 4'(STEP_SUB)) begin
          carry_d = alu.alu_carry_sub;
        end else begin
          carry_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu.alu_a       = a_q;
  assign alu.alu_b       = b_q;
  assign alu.alu_op      = ctrl_q.op;
  assign alu.alu_op_sum  = ctrl_q.op_sum;
  assign alu.alu_op_subt = ctrl_q.op_subt;

endmodule

// File: tb/tb_alu_step_driver.sv
module tb_alu_step_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DBC = 4;
  localparam int unsigned STL = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_a;
  logic [N-1:0] sw_b;
  logic         btn_load_n;
  logic         btn_next_n;
  logic [N-1:0] result_q;
  logic         carry_q;
  logic [3:0]   step_q;
  logic         done;

  alu_step_driver_if #(.N(N)) alu_bus ();

  alu_step_driver #(
    .N               (N),
    .DEBOUNCE_CYCLES (DBC),
    .SETTLE_CYCLES   (STL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_a       (sw_a),
    .sw_b       (sw_b),
    .btn_load_n (btn_load_n),
    .btn_next_n (btn_next_n),
    .alu        (alu_bus.master),
    .result_q   (result_q),
    .carry_q    (carry_q),
    .step_q     (step_q),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presses the selected buttons for 'hold' cycles and watches a fixed window.
  // lat = cycles from the first press pulse to the first done (-1 if missing).
  task automatic do_press(input logic ld, input logic nx, input int hold,
                          output int lat, output int ndone);
    int pc;
    int dc;
    pc    = -1;
    dc    = -1;
    ndone = 0;
    @(negedge clk);
    btn_load_n = ~ld;
    btn_next_n = ~nx;
    for (int cyc = 0; cyc < hold + 60; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == hold - 1) begin
        btn_load_n = 1'b1;
        btn_next_n = 1'b1;
      end
      if (pc < 0 && (dut.u_load_db.press || dut.u_next_db.press)) pc = cyc;
      if (done) begin
        ndone++;
        if (dc < 0) dc = cyc;
      end
    end
    lat = (pc >= 0 && dc >= 0) ? dc - pc : -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_a"},      32'(alu_bus.alu_a), 32'h0);
    check_val({tag, "_b"},      32'(alu_bus.alu_b), 32'h0);
    check_val({tag, "_op"},     32'(alu_bus.alu_op), 32'h7);
    check_val({tag, "_sumsub"}, 32'({alu_bus.alu_op_sum, alu_bus.alu_op_subt}), 32'h0);
    check_val({tag, "_res"},    32'(result_q), 32'h0);
    check_val({tag, "_carry"},  32'(carry_q), 32'h0);
    check_val({tag, "_step"},   32'(step_q), 32'h0);
    check_val({tag, "_done"},   32'(done), 32'h0);
  endtask

  // Expected controls after each of ten next presses starting at step 0.
  int exp_step[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
  int exp_op[10]   = '{6, 5, 4, 3, 2, 1, 0, 7, 7, 7};
  int exp_ss[10]   = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 0};

  initial begin
    int lat;
    int nd;
    int seen;
    bit done_seen;

    rst_n                 = 1'b0;
    sw_a                  = '0;
    sw_b                  = '0;
    btn_load_n            = 1'b1;
    btn_next_n            = 1'b1;
    alu_bus.alu_result    = '0;
    alu_bus.alu_carry_sum = 1'b0;
    alu_bus.alu_carry_sub = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("post_rst");

    // Load path
    sw_a               = 4'b1010;
    sw_b               = 4'b0010;
    alu_bus.alu_result = 4'b0101;
    do_press(1'b1, 1'b0, DBC + 4, lat, nd);
    check_val("load_lat",   32'(lat), 32'(STL + 3));
    check_val("load_ndone", 32'(nd), 32'd1);
    check_val("load_a",     32'(alu_bus.alu_a), 32'hA);
    check_val("load_b",     32'(alu_bus.alu_b), 32'h2);
    check_val("load_op",    32'(alu_bus.alu_op), 32'h7);
    check_val("load_step",  32'(step_q), 32'h0);
    check_val("load_res",   32'(result_q), 32'h5);

    // Step sweep through all ten modes and the wrap
    for (int i = 0; i < 10; i++) begin
      alu_bus.alu_result = 4'(i + 3);
      do_press(1'b0, 1'b1, DBC + 4, lat, nd);
      check_val($sformatf("sweep%0d_step", i),   32'(step_q), 32'(exp_step[i]));
      check_val($sformatf("sweep%0d_op", i),     32'(alu_bus.alu_op), 32'(exp_op[i]));
      check_val($sformatf("sweep%0d_sumsub", i), 32'({alu_bus.alu_op_sum, alu_bus.alu_op_subt}), 32'(exp_ss[i]));
      check_val($sformatf("sweep%0d_res", i),    32'(result_q), 32'(i + 3));
      check_val($sformatf("sweep%0d_lat", i),    32'(lat), 32'(STL + 2));
      check_val($sformatf("sweep%0d_ndone", i),  32'(nd), 32'd1);
    end

    // Carry capture
    sw_a = 4'b1111;
    sw_b = 4'b1000;
    do_press(1'b1, 1'b0, DBC + 4, lat, nd);
    for (int i = 0; i < 7; i++) do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("carry_pre_step", 32'(step_q), 32'd7);
    alu_bus.alu_result    = 4'b0111;
    alu_bus.alu_carry_sum = 1'b1;
    alu_bus.alu_carry_sub = 1'b0;
    do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("carry8_step",  32'(step_q), 32'd8);
    check_val("carry8_carry", 32'(carry_q), 32'd1);
    check_val("carry8_res",   32'(result_q), 32'h7);
    do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("carry9_step",  32'(step_q), 32'd9);
    check_val("carry9_carry", 32'(carry_q), 32'd0);
    for (int i = 0; i < 3; i++) do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    alu_bus.alu_carry_sum = 1'b1;
    alu_bus.alu_carry_sub = 1'b1;
    sw_a                  = 4'b0000;
    sw_b                  = 4'b0001;
    do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("carry3_step",  32'(step_q), 32'd3);
    check_val("carry3_carry", 32'(carry_q), 32'd0);
    check_val("sw_hold_a",    32'(alu_bus.alu_a), 32'hF);
    check_val("sw_hold_b",    32'(alu_bus.alu_b), 32'h8);

    // Debounce: short glitch, then a long hold
    do_press(1'b0, 1'b1, 2, lat, nd);
    check_val("glitch_ndone", 32'(nd), 32'd0);
    check_val("glitch_step",  32'(step_q), 32'd3);
    do_press(1'b0, 1'b1, 100, lat, nd);
    check_val("hold_ndone", 32'(nd), 32'd1);
    check_val("hold_step",  32'(step_q), 32'd4);

    // Simultaneous load and next: load wins
    sw_a = 4'b0110;
    sw_b = 4'b1001;
    do_press(1'b1, 1'b1, DBC + 4, lat, nd);
    check_val("simul_ndone", 32'(nd), 32'd1);
    check_val("simul_step",  32'(step_q), 32'd0);
    check_val("simul_a",     32'(alu_bus.alu_a), 32'h6);
    check_val("simul_b",     32'(alu_bus.alu_b), 32'h9);

    // Next press landing in WAIT after a load is dropped
    do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("ign_pre_step", 32'(step_q), 32'd1);
    @(negedge clk);
    btn_load_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_next_n = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == DBC + 1) btn_load_n = 1'b1;
      if (cyc == DBC + 4) btn_next_n = 1'b1;
      if (done) nd++;
    end
    check_val("ign_ndone", 32'(nd), 32'd1);
    check_val("ign_step",  32'(step_q), 32'd0);

    // Asynchronous reset while in WAIT
    do_press(1'b0, 1'b1, DBC + 4, lat, nd);
    check_val("rstw_pre_step", 32'(step_q), 32'd1);
    @(negedge clk);
    btn_next_n = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 50 && seen == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (dut.u_next_db.press) seen = 1;
    end
    check_val("rstw_press_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rstw");
    btn_next_n = 1'b1;
    done_seen  = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1'b1;
    end
    check_val("rstw_done_held", 32'(done_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rstw_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_step_driver.md
Name: alu_step_driver

Overview:
- Board-level sequential driver for the 4-bit ALU. It does in hardware what the ALU stimulus bench does in simulation.
- It latches operands from switches and steps through all ten ALU operating modes on debounced active-low button presses.
- For each step it drives the ALU controls, waits for the combinational paths to settle, then registers the result and carry for display.
- It sits between the board switch/button pins and the alu instance.

Parameters:
- N, 4, operand and result width.
- DEBOUNCE_CYCLES, 4, consecutive stable clocks required to accept a button level (synthesis override 500000).
- SETTLE_CYCLES, 2, clocks held in WAIT after driving the ALU before capture; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_a  input  N  operand A switches.
- sw_b  input  N  operand B switches.
- btn_load_n  input  1  load button; low = pressed.
- btn_next_n  input  1  step button; low = pressed.
- alu_result  input  N  ALU selected result.
- alu_carry_sum  input  1  ALU adder carry.
- alu_carry_sub  input  1  ALU subtractor borrow.
- alu_a  output  N  operand A to ALU.
- alu_b  output  N  operand B to ALU.
- alu_op  output  3  ALU op select.
- alu_op_sum  output  1  ALU add enable.
- alu_op_subt  output  1  ALU subtract enable.
- result_q  output  N  captured result.
- carry_q  output  1  captured carry/borrow.
- step_q  output  4  current step index 0..9.
- done  output  1  one-cycle pulse on capture.

Behaviour:
- Reset, asynchronous and active-low: all outputs 0, except alu_op = 3'b111 (step 0). FSM = IDLE. Debouncers are held at the released state (stable high). Pending press flags are cleared.
- Debounce, one instance per button:
  - Synchronise the input through 2 flops.
  - A counter increments while the synced level differs from the accepted level and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the new level is accepted.
  - A high-to-low transition of the accepted level produces a 1-cycle press pulse.
  - Holding the button produces exactly one pulse. A glitch shorter than DEBOUNCE_CYCLES produces none.
- Step decode is a pure function of step_q:
  - Steps 0..7: alu_op = ~step_q[2:0], alu_op_sum = 0, alu_op_subt = 0.
  - Step 8: alu_op = 3'b111, alu_op_sum = 1, alu_op_subt = 0.
  - Step 9: alu_op = 3'b111, alu_op_sum = 0, alu_op_subt = 1.
  - Decoded controls are registered and change only in the APPLY state.
- FSM states IDLE, LOAD, APPLY, WAIT, CAPTURE:
  - IDLE: a load pulse goes to LOAD. Otherwise a next pulse goes to APPLY after advancing step_q (9 wraps to 0).
  - IDLE, load and next pulses in the same cycle: load wins and step_q is not advanced.
  - LOAD: alu_a <= sw_a, alu_b <= sw_b, step_q <= 0, then APPLY.
  - APPLY: register the decoded controls, load the settle counter with SETTLE_CYCLES-1, go to WAIT.
  - WAIT: decrement the counter. At 0 go to CAPTURE.
  - CAPTURE: result_q <= alu_result. carry_q <= alu_carry_sum at step 8, alu_carry_sub at step 9, 0 otherwise. Pulse done = 1 and return to IDLE.
- Latency: press pulse to done = SETTLE_CYCLES + 2 clocks (next) or SETTLE_CYCLES + 3 clocks (load).
- Presses arriving outside IDLE are ignored, not queued.
- Switch changes outside LOAD have no effect on alu_a or alu_b.
- rst_n asserted mid-sequence: immediate return to reset values, no partial capture.

Decomposition:
- Package alu_drv_pkg: state enum (IDLE, LOAD, APPLY, WAIT, CAPTURE); localparam NUM_STEPS = 10; localparam STEP_SUM = 8; localparam STEP_SUB = 9.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n, press): instantiated twice.
- Step decode stays inline as combinational logic.

Test Plan:
- Reset check: assert rst_n = 0 mid-WAIT -> every output returns to reset values within the same cycle; done stays 0.
- Load path: sw_a = 4'b1010, sw_b = 4'b0010, press load for DEBOUNCE_CYCLES+4 clocks, ALU model returns 4'b0101 -> alu_a = 1010, alu_b = 0010, alu_op = 111, step_q = 0, result_q = 0101, done pulses once at SETTLE_CYCLES+3 clocks after the pulse.
- Step sweep: from step 0, ten next presses -> alu_op follows 110, 101, 100, 011, 010, 001, 000, 111, 111; at step 8 {op_sum, op_subt} = 10, at step 9 = 01; the tenth press wraps to step 0 with alu_op = 111.
- Carry capture: a = 4'b1111, b = 4'b1000, model carry_sum = 1 at step 8 -> carry_q = 1. At step 9 with carry_sub = 0 -> carry_q = 0. At step 3 with either carry = 1 -> carry_q = 0.
- Debounce: 2-clock low glitch on btn_next_n -> no step change. A held press of 100 clocks -> exactly one advance.
- Simultaneous and ignored presses: load and next pulses in the same IDLE cycle -> LOAD taken, step_q = 0. A next press during WAIT -> ignored, step_q unchanged after done.
